// File: rtl/pipeline_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// pcu_pkg : shared definitions for the pipeline control unit.
//   - pcu_state_e      : FSM state encodings (0..7; 8..15 are illegal)
//   - PC_SEL_*         : one-hot program-counter load selects
//   - CALL_LOW_DEFAULT : low bits of the injected interrupt call word
//   - CNT_W            : drain counter width (RET_DRAIN up to 15)
//   - pc_sel_for_state : Moore PC load select for a given state
// ---------------------------------------------------------------------------
package pcu_pkg;

    typedef enum logic [3:0] {
        S_NORMAL   = 4'd0,
        S_HALT     = 4'd1,
        S_IRQ      = 4'd2,
        S_STALL_F  = 4'd3,
        S_STALL_D  = 4'd4,
        S_RET      = 4'd5,
        S_RET_LOAD = 4'd6,
        S_BRANCH   = 4'd7
    } pcu_state_e;

    localparam logic [3:0] PC_SEL_BRANCH = 4'b0001;
    localparam logic [3:0] PC_SEL_INC    = 4'b0010;
    localparam logic [3:0] PC_SEL_INT    = 4'b0100;
    localparam logic [3:0] PC_SEL_RET    = 4'b1000;

    localparam logic [17:0] CALL_LOW_DEFAULT = 18'h00042;

    localparam int CNT_W = 4;

    // Every state not explicitly redirecting the PC keeps incrementing it.
    function automatic logic [3:0] pc_sel_for_state(input pcu_state_e st);
        logic [3:0] sel;
        case (st)
            S_IRQ:      sel = PC_SEL_INT;
            S_RET_LOAD: sel = PC_SEL_RET;
            S_BRANCH:   sel = PC_SEL_BRANCH;
            default:    sel = PC_SEL_INC;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_control_unit_if.sv
// ---------------------------------------------------------------------------
// pipeline_control_unit_if : decode requests in, pipeline control out.
//   master : the decode/execute side driving requests and observing controls
//   slave  : the control unit itself
// Requests : ret, reti, halt, fetch_stl_req, dec_stl_req, take_branch_target,
//            irq_req, irq_mask, int_vector_base
// Controls : stall_fetch, stall_decode, prog_cntr_load_sel, inst_word_sel,
//            new_inst_word, prog_cntr_int_addr, irq_ack, int_active,
//            control_state
// ---------------------------------------------------------------------------
interface pipeline_control_unit_if #(
    parameter int ADDR_W  = 14,
    parameter int INST_W  = 32,
    parameter int NUM_IRQ = 4
);
    logic                ret;
    logic                reti;
    logic                halt;
    logic                fetch_stl_req;
    logic                dec_stl_req;
    logic                take_branch_target;
    logic [NUM_IRQ-1:0]  irq_req;
    logic [NUM_IRQ-1:0]  irq_mask;
    logic [ADDR_W-1:0]   int_vector_base;

    logic                stall_fetch;
    logic                stall_decode;
    logic [3:0]          prog_cntr_load_sel;
    logic                inst_word_sel;
    logic [INST_W-1:0]   new_inst_word;
    logic [ADDR_W-1:0]   prog_cntr_int_addr;
    logic [NUM_IRQ-1:0]  irq_ack;
    logic                int_active;
    logic [3:0]          control_state;

    modport master (
        output ret, reti, halt, fetch_stl_req, dec_stl_req, take_branch_target,
               irq_req, irq_mask, int_vector_base,
        input  stall_fetch, stall_decode, prog_cntr_load_sel, inst_word_sel,
               new_inst_word, prog_cntr_int_addr, irq_ack, int_active,
               control_state
    );

    modport slave (
        input  ret, reti, halt, fetch_stl_req, dec_stl_req, take_branch_target,
               irq_req, irq_mask, int_vector_base,
        output stall_fetch, stall_decode, prog_cntr_load_sel, inst_word_sel,
               new_inst_word, prog_cntr_int_addr, irq_ack, int_active,
               control_state
    );
endinterface

// File: rtl/pipeline_control_unit_irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// irq_priority_encoder : picks the lowest-index pending interrupt channel.
//   pending_i : pending (requested, enabled, not blocked) channels
//   valid_o   : at least one channel pending
//   index_o   : winning channel (0 when nothing pending)
// ---------------------------------------------------------------------------
module irq_priority_encoder #(
    parameter  int NUM_IRQ = 4,
    localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] pending_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   index_o
);

    // Scan from the top down so the lowest pending index is the last write.
    always_comb begin
        valid_o = |pending_i;
        index_o = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            index_o = pending_i[i] ? IDX_W'(i) : index_o;
        end
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// ---------------------------------------------------------------------------
// pipeline_control_unit : pipeline hazard/control FSM with vectored,
// prioritised, maskable interrupts (no nesting while an ISR is active).
//   clock  : core clock, all state updates on the falling edge
//   nreset : synchronous active-low reset
//   ctl    : request/control bundle (slave side), see the interface file
// All outputs are registered Moore values derived from the next state and
// the next latched channel, so they change only on the state-update edge.
// ---------------------------------------------------------------------------
import pcu_pkg::*;

module pipeline_control_unit #(
    parameter int                        ADDR_W     = 14,
    parameter int                        INST_W     = 32,
    parameter int                        NUM_IRQ    = 4,
    parameter int                        VEC_STRIDE = 4,
    parameter int                        RET_DRAIN  = 2,
    parameter logic [INST_W-ADDR_W-1:0]  CALL_LOW   = CALL_LOW_DEFAULT
) (
    input logic                    clock,
    input logic                    nreset,
    pipeline_control_unit_if.slave ctl
);

    localparam int CH_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    // FSM and bookkeeping state
    pcu_state_e           state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [CH_W-1:0]      ch_q,     ch_d;
    logic                 active_q, active_d;
    logic                 reti_q,   reti_d;     // current return is a reti

    // Registered outputs
    logic                 stall_fetch_q,  stall_fetch_d;
    logic                 stall_decode_q, stall_decode_d;
    logic [3:0]           pc_sel_q,       pc_sel_d;
    logic                 iws_q,          iws_d;
    logic [INST_W-1:0]    word_q,         word_d;
    logic [ADDR_W-1:0]    int_addr_q,     int_addr_d;
    logic [NUM_IRQ-1:0]   ack_q,          ack_d;

    logic [NUM_IRQ-1:0]   pending_s;
    logic                 irq_valid_s;
    logic [CH_W-1:0]      irq_idx_s;
    logic [ADDR_W-1:0]    vector_s;

    // An active ISR blocks every channel so interrupts never nest.
    assign pending_s = ctl.irq_req & ctl.irq_mask & {NUM_IRQ{~active_q}};

    irq_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .pending_i (pending_s),
        .valid_o   (irq_valid_s),
        .index_o   (irq_idx_s)
    );

    // Next-state, drain counter, channel latch and ISR-active tracking.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        active_d = active_q;
        reti_d   = reti_q;
        case (state_q)
            S_NORMAL: begin
                if (ctl.ret || ctl.reti) begin
                    // reti dominates when both are decoded together
                    state_d = S_RET;
                    cnt_d   = CNT_W'(RET_DRAIN - 1);
                    reti_d  = ctl.reti;
                end else if (ctl.halt) begin
                    state_d = S_HALT;
                end else if (ctl.take_branch_target) begin
                    state_d = S_BRANCH;
                end else if (ctl.fetch_stl_req) begin
                    state_d = S_STALL_F;
                end else if (ctl.dec_stl_req) begin
                    state_d = S_STALL_D;
                end else if (irq_valid_s) begin
                    state_d = S_IRQ;
                    ch_d    = irq_idx_s;
                end else begin
                    state_d = S_NORMAL;
                end
            end
            S_HALT: begin
                if (irq_valid_s) begin
                    state_d = S_IRQ;
                    ch_d    = irq_idx_s;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_IRQ: begin
                state_d  = S_NORMAL;
                active_d = 1'b1;
            end
            S_STALL_F: begin
                if (irq_valid_s) begin
                    state_d = S_IRQ;
                    ch_d    = irq_idx_s;
                end else begin
                    state_d = S_NORMAL;
                end
            end
            S_STALL_D: begin
                if (ctl.dec_stl_req) begin
                    state_d = S_STALL_D;
                end else if (irq_valid_s) begin
                    state_d = S_IRQ;
                    ch_d    = irq_idx_s;
                end else begin
                    state_d = S_NORMAL;
                end
            end
            S_RET: begin
                // every other request is ignored while draining
                if (cnt_q == CNT_W'(0)) begin
                    state_d = S_RET_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RET_LOAD: begin
                state_d = S_NORMAL;
                if (reti_q) begin
                    active_d = 1'b0;
                end else begin
                    active_d = active_q;
                end
            end
            S_BRANCH: begin
                state_d = S_NORMAL;
            end
            default: begin
                state_d = S_NORMAL;
            end
        endcase
    end

    // Vector address wraps within ADDR_W by construction of the widths.
    assign vector_s = ctl.int_vector_base + (ADDR_W'(ch_d) * ADDR_W'(VEC_STRIDE));

    // Moore output values for the state being entered.
    always_comb begin
        stall_fetch_d  = 1'b0;
        stall_decode_d = 1'b0;
        pc_sel_d       = pc_sel_for_state(state_d);
        iws_d          = 1'b0;
        word_d         = '0;
        int_addr_d     = '0;
        ack_d          = '0;
        case (state_d)
            S_HALT, S_STALL_F, S_RET: begin
                stall_fetch_d = 1'b1;
                iws_d         = 1'b1;
            end
            S_STALL_D: begin
                stall_fetch_d  = 1'b1;
                stall_decode_d = 1'b1;
                iws_d          = 1'b1;
            end
            S_IRQ: begin
                iws_d       = 1'b1;
                word_d      = {vector_s, CALL_LOW};
                int_addr_d  = vector_s;
                ack_d[ch_d] = 1'b1;
            end
            S_RET_LOAD, S_BRANCH: begin
                iws_d = 1'b1;
            end
            default: begin
                iws_d = 1'b0;
            end
        endcase
    end

    // State and output registers, synchronous reset on the falling edge.
    always_ff @(negedge clock) begin
        if (!nreset) begin
            state_q        <= S_NORMAL;
            cnt_q          <= '0;
            ch_q           <= '0;
            active_q       <= 1'b0;
            reti_q         <= 1'b0;
            stall_fetch_q  <= 1'b0;
            stall_decode_q <= 1'b0;
            pc_sel_q       <= PC_SEL_INC;
            iws_q          <= 1'b0;
            word_q         <= '0;
            int_addr_q     <= '0;
            ack_q          <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ch_q           <= ch_d;
            active_q       <= active_d;
            reti_q         <= reti_d;
            stall_fetch_q  <= stall_fetch_d;
            stall_decode_q <= stall_decode_d;
            pc_sel_q       <= pc_sel_d;
            iws_q          <= iws_d;
            word_q         <= word_d;
            int_addr_q     <= int_addr_d;
            ack_q          <= ack_d;
        end
    end

    assign ctl.stall_fetch        = stall_fetch_q;
    assign ctl.stall_decode       = stall_decode_q;
    assign ctl.prog_cntr_load_sel = pc_sel_q;
    assign ctl.inst_word_sel      = iws_q;
    assign ctl.new_inst_word      = word_q;
    assign ctl.prog_cntr_int_addr = int_addr_q;
    assign ctl.irq_ack            = ack_q;
    assign ctl.int_active         = active_q;
    assign ctl.control_state      = state_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipeline_control_unit : directed bench for pipeline_control_unit.
// Inputs change and outputs are sampled 1 time unit after each falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_control_unit;

    logic clock;
    logic nreset;
    int   n_cmp;
    int   n_err;

    pipeline_control_unit_if #(.ADDR_W(14), .INST_W(32), .NUM_IRQ(4)) bus ();

    pipeline_control_unit #(
        .ADDR_W(14), .INST_W(32), .NUM_IRQ(4),
        .VEC_STRIDE(4), .RET_DRAIN(2), .CALL_LOW(18'h00042)
    ) dut (
        .clock  (clock),
        .nreset (nreset),
        .ctl    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Return from an ISR and confirm int_active is released.
    task automatic do_reti();
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        tick();
        tick();
        tick();
        chk("reti_clears_active", 64'(bus.int_active), 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        nreset                 = 1'b0;
        bus.ret                = 1'b0;
        bus.reti               = 1'b0;
        bus.halt               = 1'b0;
        bus.fetch_stl_req      = 1'b0;
        bus.dec_stl_req        = 1'b0;
        bus.take_branch_target = 1'b0;
        bus.irq_req            = 4'b0000;
        bus.irq_mask           = 4'b1111;
        bus.int_vector_base    = 14'h0100;
        tick();
        nreset = 1'b1;

        // reset values
        chk("rst_state",  64'(bus.control_state),      64'd0);
        chk("rst_sel",    64'(bus.prog_cntr_load_sel), 64'b0010);
        chk("rst_sf",     64'(bus.stall_fetch),        64'd0);
        chk("rst_iws",    64'(bus.inst_word_sel),      64'd0);
        chk("rst_word",   64'(bus.new_inst_word),      64'd0);
        chk("rst_ack",    64'(bus.irq_ack),            64'd0);
        chk("rst_active", 64'(bus.int_active),         64'd0);

        // reset in the middle of RET
        bus.ret = 1'b1;
        tick();
        bus.ret = 1'b0;
        chk("ret_enter", 64'(bus.control_state), 64'd5);
        chk("ret_sf",    64'(bus.stall_fetch),   64'd1);
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        chk("midret_rst_state", 64'(bus.control_state),      64'd0);
        chk("midret_rst_sel",   64'(bus.prog_cntr_load_sel), 64'b0010);
        chk("midret_rst_sf",    64'(bus.stall_fetch),        64'd0);
        chk("midret_rst_sd",    64'(bus.stall_decode),       64'd0);
        chk("midret_rst_act",   64'(bus.int_active),         64'd0);
        tick();
        chk("midret_stay_norm", 64'(bus.control_state),      64'd0);

        // branch
        bus.take_branch_target = 1'b1;
        tick();
        bus.take_branch_target = 1'b0;
        chk("br_state", 64'(bus.control_state),      64'd7);
        chk("br_sel",   64'(bus.prog_cntr_load_sel), 64'b0001);
        chk("br_iws",   64'(bus.inst_word_sel),      64'd1);
        tick();
        chk("br_back",  64'(bus.control_state),      64'd0);

        // IRQ with channels 1 and 2 pending: channel 1 wins
        bus.irq_req = 4'b0110;
        tick();
        bus.irq_req = 4'b0000;
        chk("irq_state", 64'(bus.control_state),      64'd2);
        chk("irq_sel",   64'(bus.prog_cntr_load_sel), 64'b0100);
        chk("irq_ack",   64'(bus.irq_ack),            64'b0010);
        chk("irq_addr",  64'(bus.prog_cntr_int_addr), 64'h0104);
        chk("irq_word",  64'(bus.new_inst_word),      64'h04100042);
        chk("irq_act0",  64'(bus.int_active),         64'd0);
        tick();
        chk("irq_exit",  64'(bus.control_state),      64'd0);
        chk("irq_act1",  64'(bus.int_active),         64'd1);
        chk("irq_ack0",  64'(bus.irq_ack),            64'd0);

        // no nesting; reti then the held irq is taken
        bus.irq_req = 4'b0001;
        tick();
        chk("nonest_state", 64'(bus.control_state), 64'd0);
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        chk("reti_ret1",    64'(bus.control_state), 64'd5);
        chk("reti_ret1_sf", 64'(bus.stall_fetch),   64'd1);
        tick();
        chk("reti_ret2",    64'(bus.control_state), 64'd5);
        chk("reti_ret2_sf", 64'(bus.stall_fetch),   64'd1);
        tick();
        chk("reti_load",    64'(bus.control_state),      64'd6);
        chk("reti_load_sel",64'(bus.prog_cntr_load_sel), 64'b1000);
        chk("reti_load_sf", 64'(bus.stall_fetch),        64'd0);
        tick();
        chk("reti_norm",    64'(bus.control_state), 64'd0);
        chk("reti_act",     64'(bus.int_active),    64'd0);
        tick();
        bus.irq_req = 4'b0000;
        chk("held_irq_state", 64'(bus.control_state),      64'd2);
        chk("held_irq_ack",   64'(bus.irq_ack),            64'b0001);
        chk("held_irq_addr",  64'(bus.prog_cntr_int_addr), 64'h0100);
        tick();
        do_reti();

        // ret + halt + branch together: RET wins, the others are ignored
        bus.ret = 1'b1;
        bus.halt = 1'b1;
        bus.take_branch_target = 1'b1;
        tick();
        bus.ret = 1'b0;
        chk("prio_ret1", 64'(bus.control_state), 64'd5);
        tick();
        chk("prio_ret2", 64'(bus.control_state), 64'd5);
        tick();
        chk("prio_load", 64'(bus.control_state), 64'd6);
        bus.halt = 1'b0;
        bus.take_branch_target = 1'b0;
        tick();
        chk("prio_norm", 64'(bus.control_state), 64'd0);

        // decode stall held for 3 cycles
        bus.dec_stl_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stld_state", 64'(bus.control_state), 64'd4);
            chk("stld_sf",    64'(bus.stall_fetch),   64'd1);
            chk("stld_sd",    64'(bus.stall_decode),  64'd1);
        end
        bus.dec_stl_req = 1'b0;
        tick();
        chk("stld_exit",  64'(bus.control_state), 64'd0);
        chk("stld_sd0",   64'(bus.stall_decode),  64'd0);

        // HALT with everything masked, then unmask channel 3
        bus.irq_mask = 4'b0000;
        bus.irq_req  = 4'b1111;
        bus.halt     = 1'b1;
        tick();
        bus.halt = 1'b0;
        tick();
        chk("halt_state", 64'(bus.control_state), 64'd1);
        chk("halt_sf",    64'(bus.stall_fetch),   64'd1);
        chk("halt_iws",   64'(bus.inst_word_sel), 64'd1);
        chk("halt_word",  64'(bus.new_inst_word), 64'd0);
        bus.irq_mask = 4'b1000;
        tick();
        bus.irq_req  = 4'b0000;
        bus.irq_mask = 4'b1111;
        chk("halt_irq_state", 64'(bus.control_state),      64'd2);
        chk("halt_irq_ack",   64'(bus.irq_ack),            64'b1000);
        chk("halt_irq_addr",  64'(bus.prog_cntr_int_addr), 64'h010C);
        tick();
        do_reti();

        // vector address wraps within 14 bits
        bus.int_vector_base = 14'h3FFC;
        bus.irq_req = 4'b0100;
        tick();
        bus.irq_req = 4'b0000;
        chk("wrap_addr", 64'(bus.prog_cntr_int_addr), 64'h0004);
        chk("wrap_word", 64'(bus.new_inst_word),      64'h00100042);
        chk("wrap_ack",  64'(bus.irq_ack),            64'b0100);
        bus.int_vector_base = 14'h0100;
        tick();
        do_reti();

        // fetch stall beats a pending irq, which is taken on exit
        bus.fetch_stl_req = 1'b1;
        bus.irq_req = 4'b0001;
        tick();
        bus.fetch_stl_req = 1'b0;
        chk("stlf_state", 64'(bus.control_state), 64'd3);
        chk("stlf_sf",    64'(bus.stall_fetch),   64'd1);
        chk("stlf_sd",    64'(bus.stall_decode),  64'd0);
        tick();
        bus.irq_req = 4'b0000;
        chk("stlf_irq",   64'(bus.control_state), 64'd2);
        chk("stlf_ack",   64'(bus.irq_ack),       64'b0001);
        tick();
        chk("stlf_act",   64'(bus.int_active),    64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
- Parametrised next-generation pipeline hazard/control FSM for the SoC core.
- Arbitrates halt, return, branch redirect, fetch/decode stall requests and multi-channel vectored interrupts.
- Drives fetch/decode stall lines, PC load select, instruction-word override and PC interrupt address.
- Adds over the previous generation:
  - NUM_IRQ prioritised, maskable interrupt channels with acknowledge.
  - No nesting while an ISR is active.
  - Configurable return-drain length.
  - Multi-cycle decode stall hold.

Parameters:
- ADDR_W, 14, PC / vector address width.
- INST_W, 32, instruction word width; must be > ADDR_W.
- NUM_IRQ, 4, interrupt channels; 1..16.
- VEC_STRIDE, 4, address spacing between consecutive vectors.
- RET_DRAIN, 2, stall cycles before return PC load; 1..15.
- CALL_LOW, 18'h00042, low (INST_W-ADDR_W) bits of the injected call word.

Ports:
- clock  in  1  core clock; state updates on falling edge.
- nreset  in  1  synchronous active-low reset.
- ret  in  1  return decoded.
- reti  in  1  return-from-interrupt decoded.
- halt  in  1  halt decoded.
- fetch_stl_req  in  1  fetch stall request.
- dec_stl_req  in  1  decode stall request; held high = hold stall.
- take_branch_target  in  1  branch resolved taken.
- irq_req  in  NUM_IRQ  level interrupt requests.
- irq_mask  in  NUM_IRQ  per-channel enable (1 = enabled).
- int_vector_base  in  ADDR_W  vector table base.
- stall_fetch  out  1  hold fetch stage.
- stall_decode  out  1  hold decode stage.
- prog_cntr_load_sel  out  4  one-hot: 0001 branch, 0010 increment, 0100 interrupt, 1000 return.
- inst_word_sel  out  1  1 = substitute new_inst_word.
- new_inst_word  out  INST_W  injected word.
- prog_cntr_int_addr  out  ADDR_W  interrupt vector address.
- irq_ack  out  NUM_IRQ  one-hot acknowledge, IRQ state only.
- int_active  out  1  ISR in progress.
- control_state  out  4  current state encoding.

Behaviour:
- Reset: one sampling edge with nreset=0 takes effect at any state, including mid-return or mid-stall.
  - state=NORMAL, drain counter=0, latched channel=0, int_active=0.
  - Outputs take NORMAL values: stalls 0, sel 0010, inst_word_sel 0, new_inst_word 0, int_addr 0, irq_ack 0.
- Outputs are Moore: a function of state, latched channel and counter only.
- pending = irq_req & irq_mask & {NUM_IRQ{~int_active}}. Lowest index wins.
- NORMAL (0): outputs as reset. Next-state priority:
  - ret|reti -> RET.
  - halt -> HALT.
  - take_branch_target -> BRANCH.
  - fetch_stl_req -> STALL_F.
  - dec_stl_req -> STALL_D.
  - |pending -> IRQ; latch winning channel on the same edge.
  - otherwise stay.
- HALT (1): stall_fetch=1, inst_word_sel=1, word 0. Stays until |pending, then -> IRQ with channel latched.
- IRQ (2):
  - sel 0100, inst_word_sel=1.
  - vector = int_vector_base + ch*VEC_STRIDE, truncated to ADDR_W (wraps).
  - new_inst_word = {vector, CALL_LOW}; prog_cntr_int_addr = vector.
  - irq_ack[ch]=1. Exactly one cycle, then -> NORMAL.
  - int_active is set on the exit edge.
- STALL_F (3): stall_fetch=1, inst_word_sel=1. Next: |pending -> IRQ, else NORMAL.
- STALL_D (4): stall_fetch=1, stall_decode=1, inst_word_sel=1.
  - Remains while dec_stl_req=1.
  - Then |pending -> IRQ, else NORMAL.
- RET (5):
  - Entry loads the drain counter with RET_DRAIN-1 and records whether the cause was reti.
  - stall_fetch=1, inst_word_sel=1; counter decrements each cycle.
  - At 0 -> RET_LOAD. Total RET cycles = RET_DRAIN.
  - halt, branch, stall requests and irq are ignored during RET/RET_LOAD.
- RET_LOAD (6): sel 1000, inst_word_sel=1, stalls 0. Then -> NORMAL. If the cause was reti, int_active clears on this exit edge.
- BRANCH (7): sel 0001, inst_word_sel=1. Then -> NORMAL.
- Illegal encodings (8-15): NORMAL outputs, next -> NORMAL.
- Simultaneous ret and reti: treated as reti.
- An irq raised during ISR (int_active=1) is held pending and taken after RET_LOAD for reti.

Decomposition:
- Shared package pcu_pkg:
  - state encodings (S_NORMAL..S_BRANCH).
  - PC_SEL_BRANCH/INC/INT/RET one-hot constants.
  - default CALL_LOW.
- Sub-module irq_priority_encoder (NUM_IRQ): inputs pending; outputs valid and index. Lowest-index-first.

Test Plan:
- Reset mid-RET (state 5, counter 1), nreset=0 one edge -> control_state=0, sel 0010, int_active=0, all stalls 0.
- irq_req=4'b0110, mask=4'b1111, base=14'h0100, VEC_STRIDE=4, in NORMAL -> IRQ one cycle:
  - irq_ack=0010, prog_cntr_int_addr=14'h0104.
  - new_inst_word={14'h0104,18'h00042}.
  - then int_active=1.
- With int_active=1, irq_req=0001 -> no IRQ entry. Then reti:
  - RET for 2 cycles (stall_fetch=1), RET_LOAD sel 1000, int_active=0.
  - Next NORMAL cycle enters IRQ with irq_ack=0001.
- ret, halt and take_branch_target asserted in the same NORMAL cycle -> RET path taken; halt and branch ignored.
- dec_stl_req high for 3 cycles -> STALL_D for 3 cycles with stall_fetch=stall_decode=1, then NORMAL.
- HALT with irq_mask=0 and irq_req=1111 -> stays HALT. Set mask=1000 -> IRQ, ack=1000, address=base+12.
